// File: rtl/imem_responder_pkg.sv
// Shared constants and FSM state type for the instruction memory responder.
package imem_pkg;

  localparam int IM_AW    = 7;
  localparam int IM_DW    = 32;
  localparam int IM_DEPTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } imem_state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch read port plus byte-stream loader handshake, bundled for the responder.
interface imem_responder_if
  import imem_pkg::*;
#(
  parameter int AW = IM_AW,
  parameter int DW = IM_DW
) ();

  logic [AW-1:0] addra;
  logic [DW-1:0] douta;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;

  modport master (
    output addra, ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  douta, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  addra, ld_start, ld_base, ld_len, ld_valid, ld_data,
    output douta, ld_ready, ld_busy, ld_done
  );

endinterface

// File: rtl/imem_responder_ram.sv
// Simple dual-port instruction RAM: one synchronous read-first read port, one write port.
module imem_ram
  import imem_pkg::*;
#(
  parameter int AW = IM_AW,
  parameter int DW = IM_DW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Read samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a fetch read port and a byte-serial loader that packs
// four little-endian bytes per word and writes consecutive words from a base address.
module imem_responder
  import imem_pkg::*;
#(
  parameter int AW = IM_AW,
  parameter int DW = IM_DW
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  bus
);

  localparam logic [AW-1:0] ONE_ADDR = 1;
  localparam logic [AW:0]   ONE_LEN  = 1;

  imem_state_e   r_state;
  imem_state_e   w_next_state;
  logic [AW-1:0] r_wr_addr;
  logic [AW:0]   r_remaining;
  logic [1:0]    r_byte_cnt;
  logic [DW-1:0] r_word;
  logic          r_rd_valid;
  logic          w_accept;
  logic          w_we;
  logic          w_ram_we;
  logic [DW-1:0] w_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ld_start) begin
          w_next_state = (bus.ld_len == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        w_accept = bus.ld_valid;
        if (w_accept && (r_byte_cnt == 2'd3)) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        w_we         = 1'b1;
        w_next_state = (r_remaining == ONE_LEN) ? DONE : COLLECT;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Reset drops any partially assembled word but never touches the RAM contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_addr   <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.ld_start) begin
            r_wr_addr   <= bus.ld_base;
            r_remaining <= bus.ld_len;
            r_byte_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_word[{r_byte_cnt, 3'b000} +: 8] <= bus.ld_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          r_wr_addr   <= r_wr_addr + ONE_ADDR;
          r_remaining <= r_remaining - ONE_LEN;
          r_byte_cnt  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_ram_we = w_we & rst;

  imem_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(r_wr_addr),
    .i_wdata(r_word),
    .i_raddr(bus.addra),
    .o_rdata(w_rdata)
  );

  // The RAM output has no reset, so it is masked until the first post-reset read lands.
  assign bus.douta    = r_rd_valid ? w_rdata : '0;
  assign bus.ld_ready = (r_state == COLLECT);
  assign bus.ld_busy  = (r_state != IDLE);
  assign bus.ld_done  = (r_state == DONE);

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: directed table, hand-written corner sequences and random
// load sessions, all checked against a word-level memory model kept here.
module tb_imem_responder;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  imem_responder_if #(.AW(AW), .DW(DW)) bus ();

  imem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] modelMem   [DEPTH];
  bit          modelKnown [DEPTH];
  bit          busyM, doneM, pend, lastAcc, randAddr;
  logic [6:0]  pendAddr, sessBase;
  logic [31:0] pendWord, asmWord;
  int          nBytes, wordsDone, sessLen;

  typedef struct {
    logic [6:0]        base;
    int                len;
    logic [63:0]       bytesP;
    logic [2:0][6:0]   rdAddr;
    logic [2:0][31:0]  rdExp;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [31:0] initWord(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // One clock: the model applies the session rules to what was driven before the edge.
  task automatic cycle(input bit chkRd);
    logic [6:0]  ra, basePre;
    logic [31:0] expRd;
    logic [7:0]  dataPre;
    bit          rdKnown, rstPre, startPre, busyPre, donePre, pendPre, readyPre, acc;
    int          lenPre;
    ra       = bus.addra;
    expRd    = modelMem[ra];
    rdKnown  = modelKnown[ra];
    rstPre   = !rst;
    startPre = bus.ld_start;
    basePre  = bus.ld_base;
    lenPre   = int'(bus.ld_len);
    dataPre  = bus.ld_data;
    busyPre  = busyM;
    donePre  = doneM;
    pendPre  = pend;
    readyPre = busyPre && !donePre && !pendPre;
    acc      = !rstPre && readyPre && bus.ld_valid;
    @(posedge clk);
    #1;
    lastAcc = acc;
    if (rstPre) begin
      busyM = 0; doneM = 0; pend = 0; nBytes = 0;
      expRd = '0; rdKnown = 1;
    end else begin
      if (donePre) begin
        doneM = 0; busyM = 0;
      end else if (pendPre) begin
        modelMem[pendAddr]   = pendWord;
        modelKnown[pendAddr] = 1;
        pend = 0;
        wordsDone++;
        if (wordsDone == sessLen) doneM = 1;
      end else if (acc) begin
        asmWord[8*nBytes +: 8] = dataPre;
        nBytes++;
        if (nBytes == 4) begin
          pend     = 1;
          pendAddr = sessBase + 7'(wordsDone);
          pendWord = asmWord;
          nBytes   = 0;
        end
      end
      if (!busyPre && startPre) begin
        busyM = 1; sessBase = basePre; sessLen = lenPre;
        wordsDone = 0; nBytes = 0;
        if (lenPre == 0) doneM = 1;
      end
    end
    if (chkRd && rdKnown) checkOutput("douta", bus.douta, expRd);
    checkOutput("ld_busy",  32'(bus.ld_busy),  32'(busyM));
    checkOutput("ld_done",  32'(bus.ld_done),  32'(doneM));
    checkOutput("ld_ready", 32'(bus.ld_ready), 32'(busyM && !doneM && !pend));
    if (randAddr) bus.addra = 7'($urandom);
  endtask

  task automatic startSession(input logic [6:0] base, input int len);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_len   = 8'(len);
    cycle(1);
    bus.ld_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int  gap;
    bit  got;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    bus.ld_valid = 1'b0;
    repeat (gap) cycle(1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    got = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1);
      if (lastAcc) begin
        got = 1;
        break;
      end
    end
    if (!got) timeoutFail("byte_accept");
    bus.ld_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100; i++) begin
      if (!busyM) break;
      cycle(1);
    end
    if (busyM) timeoutFail("session_end");
  endtask

  task automatic applyStimulus(input logic [6:0] base, input int len,
                               input logic [7:0] bytesQ[$], input int maxGap);
    startSession(base, len);
    foreach (bytesQ[k]) sendByte(bytesQ[k], maxGap);
    waitIdle();
  endtask

  task automatic readWord(input logic [6:0] a);
    bus.addra = a;
    cycle(1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  q[$];
    logic [31:0] w;
    logic [6:0]  rb;
    int          rl;

    bus.addra = '0; bus.ld_start = 0; bus.ld_base = '0; bus.ld_len = '0;
    bus.ld_valid = 0; bus.ld_data = '0;
    randAddr = 0;

    rst = 1'b0;
    repeat (3) cycle(1);
    checkOutput("reset_douta", bus.douta, 32'h0);
    checkOutput("reset_ready", 32'(bus.ld_ready), 32'h0);
    rst = 1'b1;

    // Fill the whole array so every later read has a known expectation.
    q = {};
    for (int a = 0; a < DEPTH; a++) begin
      w = initWord(a);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    end
    applyStimulus(7'd0, 128, q, 0);

    vecs[0] = '{base: 7'd0,   len: 2, bytesP: 64'h76543210_DF9B5713,
                rdAddr: {7'd2, 7'd1, 7'd0},
                rdExp:  {initWord(2), 32'h76543210, 32'hDF9B5713}};
    vecs[1] = '{base: 7'd127, len: 2, bytesP: 64'h08070605_04030201,
                rdAddr: {7'd1, 7'd0, 7'd127},
                rdExp:  {32'h76543210, 32'h08070605, 32'h04030201}};
    vecs[2] = '{base: 7'd5,   len: 0, bytesP: 64'h0,
                rdAddr: {7'd4, 7'd6, 7'd5},
                rdExp:  {initWord(4), initWord(6), initWord(5)}};
    vecs[3] = '{base: 7'd60,  len: 1, bytesP: 64'h00000000_DDCCBBAA,
                rdAddr: {7'd59, 7'd61, 7'd60},
                rdExp:  {initWord(59), initWord(61), 32'hDDCCBBAA}};

    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int k = 0; k < 4 * vecs[v].len; k++) q.push_back(vecs[v].bytesP[8*k +: 8]);
      applyStimulus(vecs[v].base, vecs[v].len, q, 2);
      for (int j = 0; j < 3; j++) begin
        readWord(vecs[v].rdAddr[j]);
        checkOutput("tbl_rd", bus.douta, vecs[v].rdExp[j]);
      end
    end

    // A second start while collecting must not retarget the session.
    startSession(7'd20, 1);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    bus.ld_start = 1'b1; bus.ld_base = 7'd40; bus.ld_len = 8'd3;
    cycle(1);
    bus.ld_start = 1'b0;
    sendByte(8'h33, 0);
    sendByte(8'h44, 1);
    waitIdle();
    cycle(1);
    checkOutput("ign_start_busy", 32'(bus.ld_busy), 32'h0);
    readWord(7'd20);
    checkOutput("ign_start_word", bus.douta, 32'h44332211);
    readWord(7'd40);
    checkOutput("ign_start_other", bus.douta, initWord(40));

    // Read of address 5 in the same cycle its write lands returns the old word.
    bus.addra = 7'd5;
    startSession(7'd5, 1);
    sendByte(8'hE1, 0);
    sendByte(8'hE2, 0);
    sendByte(8'hE3, 0);
    sendByte(8'hE4, 0);
    cycle(1);
    checkOutput("rdw_old", bus.douta, initWord(5));
    cycle(1);
    checkOutput("rdw_new", bus.douta, 32'hE4E3E2E1);
    waitIdle();

    // Reset after six of eight bytes keeps the first word only.
    startSession(7'd10, 2);
    for (int k = 0; k < 6; k++) sendByte(8'h21 + 8'(k), 1);
    rst = 1'b0;
    cycle(1);
    rst = 1'b1;
    checkOutput("rst_douta", bus.douta, 32'h0);
    checkOutput("rst_busy",  32'(bus.ld_busy),  32'h0);
    checkOutput("rst_done",  32'(bus.ld_done),  32'h0);
    checkOutput("rst_ready", 32'(bus.ld_ready), 32'h0);
    readWord(7'd10);
    checkOutput("rst_kept", bus.douta, 32'h24232221);
    readWord(7'd11);
    checkOutput("rst_untouched", bus.douta, initWord(11));

    // Random sessions with random gaps, stray starts, stray bytes and resets.
    randAddr = 1;
    for (int s = 0; s < 40; s++) begin
      rb = 7'($urandom);
      rl = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(5, 1));
      bus.ld_valid = 1'($urandom);
      bus.ld_data  = 8'($urandom);
      repeat (int'($urandom_range(3, 0))) cycle(1);
      bus.ld_valid = 1'b0;
      startSession(rb, rl);
      for (int k = 0; k < 4 * rl; k++) begin
        if (k == 2 && $urandom_range(3, 0) == 0) begin
          bus.ld_start = 1'b1; bus.ld_base = 7'($urandom); bus.ld_len = 8'($urandom_range(128, 0));
          cycle(1);
          bus.ld_start = 1'b0;
        end
        if (k == 5 && $urandom_range(7, 0) == 0) begin
          rst = 1'b0;
          cycle(1);
          rst = 1'b1;
          break;
        end
        sendByte(8'($urandom), 3);
      end
      waitIdle();
    end
    randAddr = 0;
    repeat (2) cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
